// File: rtl/seven_seg_capture_pkg.sv
// Shared definitions for the 7-segment bus reader: active-low segment patterns ({g..a})
// and FSM state codes. The same patterns are used by the display encoder.
package seven_seg_capture_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HELD   = 2'd2
    } state_t;

endpackage

// File: rtl/seven_seg_capture_seg7_to_hex.sv
// Combinational decoder from an active-low segment pattern back to a hex nibble.
// hit=1 for one of the 16 hex glyphs, blank=1 for all segments off.
module seven_seg_capture_seg7_to_hex
    import seven_seg_capture_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic       hit_o,
    output logic       blank_o,
    output logic [3:0] nibble_o
);

    // Pattern lookup; anything outside the glyph table is neither hit nor blank
    always_comb begin
        hit_o    = 1'b1;
        blank_o  = 1'b0;
        nibble_o = 4'h0;
        case (seg_i)
            SEG_0:     nibble_o = 4'h0;
            SEG_1:     nibble_o = 4'h1;
            SEG_2:     nibble_o = 4'h2;
            SEG_3:     nibble_o = 4'h3;
            SEG_4:     nibble_o = 4'h4;
            SEG_5:     nibble_o = 4'h5;
            SEG_6:     nibble_o = 4'h6;
            SEG_7:     nibble_o = 4'h7;
            SEG_8:     nibble_o = 4'h8;
            SEG_9:     nibble_o = 4'h9;
            SEG_A:     nibble_o = 4'hA;
            SEG_B:     nibble_o = 4'hB;
            SEG_C:     nibble_o = 4'hC;
            SEG_D:     nibble_o = 4'hD;
            SEG_E:     nibble_o = 4'hE;
            SEG_F:     nibble_o = 4'hF;
            SEG_BLANK: begin
                hit_o   = 1'b0;
                blank_o = 1'b1;
            end
            default:   hit_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_seg_capture.sv
// Reads back a multiplexed active-low seg/an/dp bus: waits for each anode dwell to settle,
// decodes the digit and assembles complete frames, flagging bad glyphs and anode overlap.
module seven_seg_capture
    import seven_seg_capture_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                    MCLK,
    input  logic                    reset,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   an,
    input  logic                    dp,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic [NUM_DIGITS-1:0]   dp_out,
    output logic                    frame_done,
    output logic [4*NUM_DIGITS-1:0] frame_value,
    output logic                    pattern_err,
    output logic                    anode_err,
    output logic [ERR_CNT_W-1:0]    err_count
);

    localparam int              CNT_W      = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] SETTLE_MAX = CNT_W'(SETTLE_CYCLES);

    logic [6:0]              seg_q;
    logic [NUM_DIGITS-1:0]   an_q;
    logic                    dp_q;
    logic [CNT_W-1:0]        stable_q, stable_d;
    state_t                  state_q, state_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d;
    logic [NUM_DIGITS-1:0]   dp_out_q, dp_out_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic                    frame_done_q, frame_done_d;
    logic [4*NUM_DIGITS-1:0] frame_value_q, frame_value_d;
    logic                    pattern_err_q, pattern_err_d;
    logic                    anode_err_q, anode_err_d;
    logic [ERR_CNT_W-1:0]    err_q, err_d;

    logic       chg_s;
    logic       onehot_in_s;
    logic       multi_in_s;
    logic       multi_q_s;
    logic       capture_s;
    logic       hit_s;
    logic       blank_s;
    logic [3:0] nibble_s;

    seven_seg_capture_seg7_to_hex u_dec (
        .seg_i    (seg_q),
        .hit_o    (hit_s),
        .blank_o  (blank_s),
        .nibble_o (nibble_s)
    );

    // chg_s means seg_q/an_q take a new value on this edge, so the count restarts in step with them
    always_comb begin
        chg_s       = (seg != seg_q) || (an != an_q);
        onehot_in_s = $onehot(~an);
        multi_in_s  = !$onehot0(~an);
        multi_q_s   = !$onehot0(~an_q);
        if (chg_s) begin
            stable_d = {CNT_W{1'b0}};
        end else if (stable_q != SETTLE_MAX) begin
            stable_d = stable_q + CNT_W'(1);
        end else begin
            stable_d = stable_q;
        end
    end

    // Dwell FSM: one capture per settled anode dwell
    always_comb begin
        state_d   = state_q;
        capture_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (onehot_in_s) begin
                    state_d = ST_SETTLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (chg_s) begin
                    state_d = onehot_in_s ? ST_SETTLE : ST_IDLE;
                end else if (stable_d == SETTLE_MAX) begin
                    capture_s = 1'b1;
                    state_d   = ST_HELD;
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            ST_HELD: begin
                if (chg_s) begin
                    state_d = onehot_in_s ? ST_SETTLE : ST_IDLE;
                end else begin
                    state_d = ST_HELD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Digit capture, frame assembly and error accounting
    always_comb begin
        digits_d      = digits_q;
        valid_d       = valid_q;
        dp_out_d      = dp_out_q;
        seen_d        = seen_q;
        frame_done_d  = 1'b0;
        frame_value_d = frame_value_q;
        pattern_err_d = capture_s && !hit_s && !blank_s;
        anode_err_d   = multi_in_s && !multi_q_s;
        err_d         = err_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (capture_s && !an_q[i]) begin
                if (hit_s) begin
                    digits_d[4*i +: 4] = nibble_s;
                    valid_d[i]         = 1'b1;
                    dp_out_d[i]        = ~dp_q;
                    seen_d[i]          = 1'b1;
                end else if (blank_s) begin
                    valid_d[i] = 1'b0;
                    seen_d[i]  = 1'b1;
                end else begin
                    valid_d[i] = 1'b0;
                end
            end else begin
                valid_d[i] = valid_q[i];
            end
        end
        // The completing digit is already merged into digits_d, so the snapshot includes it
        if (capture_s && (&seen_d)) begin
            frame_done_d  = 1'b1;
            frame_value_d = digits_d;
            seen_d        = {NUM_DIGITS{1'b0}};
        end else begin
            frame_done_d  = 1'b0;
        end
        if ((pattern_err_d || anode_err_d) && (err_q != {ERR_CNT_W{1'b1}})) begin
            err_d = err_q + ERR_CNT_W'(1);
        end else begin
            err_d = err_q;
        end
    end

    // State and output registers
    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            seg_q         <= 7'h7F;
            an_q          <= {NUM_DIGITS{1'b1}};
            dp_q          <= 1'b1;
            stable_q      <= {CNT_W{1'b0}};
            state_q       <= ST_IDLE;
            digits_q      <= {(4*NUM_DIGITS){1'b0}};
            valid_q       <= {NUM_DIGITS{1'b0}};
            dp_out_q      <= {NUM_DIGITS{1'b0}};
            seen_q        <= {NUM_DIGITS{1'b0}};
            frame_done_q  <= 1'b0;
            frame_value_q <= {(4*NUM_DIGITS){1'b0}};
            pattern_err_q <= 1'b0;
            anode_err_q   <= 1'b0;
            err_q         <= {ERR_CNT_W{1'b0}};
        end else begin
            seg_q         <= seg;
            an_q          <= an;
            dp_q          <= dp;
            stable_q      <= stable_d;
            state_q       <= state_d;
            digits_q      <= digits_d;
            valid_q       <= valid_d;
            dp_out_q      <= dp_out_d;
            seen_q        <= seen_d;
            frame_done_q  <= frame_done_d;
            frame_value_q <= frame_value_d;
            pattern_err_q <= pattern_err_d;
            anode_err_q   <= anode_err_d;
            err_q         <= err_d;
        end
    end

    assign digits      = digits_q;
    assign digit_valid = valid_q;
    assign dp_out      = dp_out_q;
    assign frame_done  = frame_done_q;
    assign frame_value = frame_value_q;
    assign pattern_err = pattern_err_q;
    assign anode_err   = anode_err_q;
    assign err_count   = err_q;

endmodule
